// File: rtl/fetch_responder.sv
// fetch_responder: toggle-handshake instruction fetch front end.
// Define FETCH_PREFETCH_EN to add a 2-entry prefetch queue behind the slot.
module fetch_responder #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        triggerIn,
   output logic        readyOut,
   output logic [31:0] dataOut,
   output logic [31:0] pcOut,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   input  logic        branchValid,
   input  logic [31:0] branchTarget
);

   typedef enum logic {IDLE, REQ} state_t;

`ifdef FETCH_PREFETCH_EN
   localparam logic [1:0] CAP = 2'd3;
`else
   localparam logic [1:0] CAP = 2'd1;
`endif

   state_t      state, stateN;
   logic        sync1, sync2, hist;
   logic        toggle, take, accept, direct;
   logic        valid, validN;
   logic [31:0] data, dataN;
   logic [31:0] pc, pcN;
   logic [31:0] fpc, fpcN;
   logic [1:0]  qCnt, qCntN;
   logic [31:0] qHeadData, qHeadPc;
   logic [1:0]  occN;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= 1'b0;
      end else begin
         sync1 <= triggerIn;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   // A redirect in the same cycle absorbs both the toggle and the ack.
   assign toggle = sync2 ^ hist;
   assign take   = toggle & valid & ~branchValid;
   assign accept = (state == REQ) & imemAck & ~branchValid;
   assign direct = accept & ~valid & (qCnt == 2'd0);

`ifdef FETCH_PREFETCH_EN
   logic [31:0] qData [2];
   logic [31:0] qPc [2];
   logic [31:0] qDataN [2];
   logic [31:0] qPcN [2];
   logic        pop, push;

   assign pop       = ~branchValid & ~valid & (qCnt != 2'd0);
   assign push      = accept & ~direct;
   assign qHeadData = qData[0];
   assign qHeadPc   = qPc[0];

   always_comb begin
      qDataN = qData;
      qPcN   = qPc;
      qCntN  = qCnt;
      if (branchValid) begin
         qCntN = 2'd0;
      end else begin
         if (pop) begin
            qDataN[0] = qData[1];
            qPcN[0]   = qPc[1];
            qCntN     = qCnt - 2'd1;
         end
         if (push) begin
            qDataN[qCntN[0]] = imemData;
            qPcN[qCntN[0]]   = fpc;
            qCntN            = qCntN + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         qCnt     <= 2'd0;
         qData[0] <= '0;
         qData[1] <= '0;
         qPc[0]   <= '0;
         qPc[1]   <= '0;
      end else begin
         qCnt  <= qCntN;
         qData <= qDataN;
         qPc   <= qPcN;
      end
   end
`else
   assign qCnt      = 2'd0;
   assign qCntN     = 2'd0;
   assign qHeadData = '0;
   assign qHeadPc   = '0;
`endif

   // The slot never reloads on the consuming edge, so readyOut idles a cycle.
   always_comb begin
      validN = valid;
      dataN  = data;
      pcN    = pc;
      if (branchValid || take) begin
         validN = 1'b0;
      end else if (!valid && qCnt != 2'd0) begin
         validN = 1'b1;
         dataN  = qHeadData;
         pcN    = qHeadPc;
      end else if (direct) begin
         validN = 1'b1;
         dataN  = imemData;
         pcN    = fpc;
      end
   end

   always_comb begin
      occN   = {1'b0, validN} + qCntN;
      stateN = state;
      fpcN   = fpc;
      if (branchValid) begin
         stateN = IDLE;
         fpcN   = branchTarget & 32'hFFFF_FFFC;
      end else begin
         if (accept) begin
            fpcN = fpc + 32'd4;
         end
         unique case (state)
            IDLE: if (occN < CAP) stateN = REQ;
            REQ:  if (accept && occN >= CAP) stateN = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         valid <= 1'b0;
         data  <= '0;
         pc    <= '0;
         fpc   <= RESET_VECTOR & 32'hFFFF_FFFC;
      end else begin
         state <= stateN;
         valid <= validN;
         data  <= dataN;
         pc    <= pcN;
         fpc   <= fpcN;
      end
   end

   assign readyOut = valid;
   assign dataOut  = data;
   assign pcOut    = pc;
   assign imemReq  = (state == REQ);
   assign imemAddr = fpc;

endmodule

// File: tb/tb_fetch_responder.sv
// tb_fetch_responder: directed and randomized checks of fetch_responder
// against an in-order word-stream model and an address-hashed memory.
module tb_fetch_responder;

`ifdef FETCH_PREFETCH_EN
   localparam int EXP_ACKS = 3;
`else
   localparam int EXP_ACKS = 1;
`endif

   logic        clk;
   logic        reset;
   logic        triggerIn;
   logic        readyOut;
   logic [31:0] dataOut;
   logic [31:0] pcOut;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck = 1'b0;
   logic [31:0] imemData = '0;
   logic        branchValid;
   logic [31:0] branchTarget;

   int          tests = 0;
   int          fails = 0;
   int          lat = 2;
   bit          randLat = 0;
   int          waitCnt = 0;
   int          rl = 0;
   int          ackCount = 0;
   logic [31:0] ackAddrs[$];
   logic [31:0] expPc;

   fetch_responder dut (
      .clk          (clk),
      .reset        (reset),
      .triggerIn    (triggerIn),
      .readyOut     (readyOut),
      .dataOut      (dataOut),
      .pcOut        (pcOut),
      .imemReq      (imemReq),
      .imemAddr     (imemAddr),
      .imemAck      (imemAck),
      .imemData     (imemData),
      .branchValid  (branchValid),
      .branchTarget (branchTarget)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h0100_0193) ^ 32'hE3A0_0001;
   endfunction

   // Memory: acks a held request after the chosen number of wait cycles.
   always @(negedge clk) begin
      imemAck  = 1'b0;
      imemData = $urandom;
      if (imemReq) begin
         if (waitCnt >= (randLat ? rl : lat)) begin
            imemAck  = 1'b1;
            imemData = memWord(imemAddr);
            waitCnt  = 0;
            rl       = $urandom_range(0, 3);
         end else begin
            waitCnt++;
         end
      end else begin
         waitCnt = 0;
      end
   end

   always @(posedge clk) begin
      if (!reset && imemReq && imemAck && !branchValid) begin
         ackCount++;
         ackAddrs.push_back(imemAddr);
      end
   end

   task automatic check32(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic waitReady(output int low);
      low = 0;
      while (!readyOut && low < 40) begin
         low++;
         @(negedge clk);
      end
      check1("ready_timeout", readyOut, 1'b1);
   endtask

   task automatic checkWord();
      check32("word_pc", pcOut, expPc);
      check32("word_data", dataOut, memWord(expPc));
      expPc = expPc + 32'd4;
   endtask

   task automatic consume();
      logic [31:0] hp, hd;
      int          n, low;
      bit          stable;
      hp = pcOut;
      hd = dataOut;
      stable = 1'b1;
      triggerIn = ~triggerIn;
      n = 0;
      while (readyOut && n < 8) begin
         @(negedge clk);
         n++;
         if (readyOut && (pcOut !== hp || dataOut !== hd)) stable = 1'b0;
      end
      check1("ready_drop", readyOut, 1'b0);
      check1("stable_hold", stable, 1'b1);
      waitReady(low);
      check1("gap_ge1", low >= 1, 1'b1);
      checkWord();
   endtask

   task automatic branch(input logic [31:0] t);
      branchValid  = 1'b1;
      branchTarget = t;
      @(negedge clk);
      branchValid = 1'b0;
      expPc = t & 32'hFFFF_FFFC;
   endtask

   task automatic awaitReq();
      int n;
      n = 0;
      while (!imemReq && n < 10) begin
         @(negedge clk);
         n++;
      end
      check1("req_wait", imemReq, 1'b1);
   endtask

   initial begin
      int low;
      int ackBase;
      int qs;
      reset        = 1'b1;
      triggerIn    = 1'b0;
      branchValid  = 1'b0;
      branchTarget = '0;
      expPc        = '0;

      repeat (3) @(negedge clk);
      check1("rst_ready", readyOut, 1'b0);
      check32("rst_data", dataOut, 32'h0);
      check32("rst_pc", pcOut, 32'h0);
      check1("rst_req", imemReq, 1'b0);
      check32("rst_addr", imemAddr, 32'h0);

      lat   = 2;
      reset = 1'b0;
      @(negedge clk);
      check1("boot_req", imemReq, 1'b1);
      check32("boot_addr", imemAddr, 32'h0);
      waitReady(low);
      check32("boot_data", dataOut, 32'hE3A0_0001);
      checkWord();

      lat   = 0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      ackBase = ackCount;
      reset   = 1'b0;
      expPc   = '0;
      repeat (12) @(negedge clk);
      check32("ack_count", 32'(ackCount - ackBase), 32'(EXP_ACKS));
      check1("fill_req", imemReq, 1'b0);
      check1("fill_ready", readyOut, 1'b1);
      checkWord();
      repeat (3) consume();

      lat = 5;
      triggerIn = ~triggerIn;
      awaitReq();
      branch(32'h0000_0102);
      check1("redir_req_drop", imemReq, 1'b0);
      check1("redir_ready", readyOut, 1'b0);
      lat = 1;
      @(negedge clk);
      check1("redir_req", imemReq, 1'b1);
      check32("redir_addr", imemAddr, 32'h0000_0100);
      waitReady(low);
      checkWord();

      lat = 0;
      repeat (8) @(negedge clk);
      triggerIn = ~triggerIn;
      awaitReq();
      branch(32'h0000_0300);
      waitReady(low);
      checkWord();

      repeat (8) @(negedge clk);
      triggerIn = ~triggerIn;
      repeat (2) @(negedge clk);
      branch(32'h0000_0200);
      waitReady(low);
      checkWord();
      repeat (6) @(negedge clk);
      check1("absorb_ready", readyOut, 1'b1);
      check32("absorb_pc", pcOut, 32'h0000_0200);
      consume();

      qs = ackAddrs.size();
      branch(32'hFFFF_FFFC);
      waitReady(low);
      checkWord();
      consume();
      check1("wrap_acks", ackAddrs.size() >= qs + 2, 1'b1);
      if (ackAddrs.size() >= qs + 2) begin
         check32("wrap_addr0", ackAddrs[qs], 32'hFFFF_FFFC);
         check32("wrap_addr1", ackAddrs[qs + 1], 32'h0000_0000);
      end

      randLat = 1'b1;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            branch($urandom);
            waitReady(low);
            checkWord();
         end else begin
            consume();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
